// File: rtl/seq_decoder_2to4_pkg.sv
// Shared definitions for the registered 2-to-4 decoder: state encodings,
// counter width and the default hold length.
package seq_decoder_2to4_pkg;

  // 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  localparam int CNT_W            = 8;
  localparam int HOLD_CYCLES_DFLT = 4;

endpackage

// File: rtl/seq_decoder_2to4_hold_timer.sv
// Loadable down-counter that times how long a decoded line stays asserted.
// It saturates at zero, so the count can never wrap.
import seq_decoder_2to4_pkg::*;

module seq_decoder_2to4_hold_timer (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] ld_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= ld_val;
    else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/seq_decoder_2to4.sv
// Registered N_SEL-to-2**N_SEL decoder. A valid index drives a one-hot line
// for HOLD_CYCLES cycles and then releases it with a done pulse; scan mode
// walks a single 1 across the outputs while scan_en stays high.
import seq_decoder_2to4_pkg::*;

module seq_decoder_2to4 #(
  parameter int N_SEL       = 2,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DFLT  // legal 1..255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                v,
  input  logic [N_SEL-1:0]    y,
  input  logic                scan_en,
  output logic [2**N_SEL-1:0] Q,
  output logic                busy,
  output logic                done
);

  localparam int              W   = 2**N_SEL;
  localparam logic [W-1:0]    ONE = W'(1);
  // Q is loaded at the accept edge, so the counter starts one below the
  // hold length and exit happens on the edge that sees zero.
  localparam logic [CNT_W-1:0] LD_VAL = CNT_W'(HOLD_CYCLES - 1);

  state_t       state, state_nxt;
  logic [W-1:0] q_nxt;
  logic         done_nxt;
  logic         tmr_load, tmr_dec, tmr_zero;

  seq_decoder_2to4_hold_timer u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .dec    (tmr_dec),
    .ld_val (LD_VAL),
    .zero   (tmr_zero)
  );

  // State and output registers; busy mirrors the next state being non-idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      Q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      Q     <= q_nxt;
      busy  <= (state_nxt != ST_IDLE);
      done  <= done_nxt;
    end
  end

  // Next-state and next-output decode; unknown states fall back to idle with Q cleared.
  always_comb begin
    state_nxt = state;
    q_nxt     = Q;
    done_nxt  = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        q_nxt = '0;
        if (v) begin
          state_nxt = ST_HOLD;
          q_nxt     = ONE << y;
          tmr_load  = 1'b1;
        end else if (scan_en) begin
          state_nxt = ST_SCAN;
          q_nxt     = ONE;
        end
      end
      ST_HOLD: begin
        // Requests are dropped here, not queued.
        if (tmr_zero) begin
          state_nxt = ST_IDLE;
          q_nxt     = '0;
          done_nxt  = 1'b1;
        end else begin
          tmr_dec   = 1'b1;
        end
      end
      ST_SCAN: begin
        if (scan_en) begin
          q_nxt = {Q[W-2:0], Q[W-1]};
        end else begin
          state_nxt = ST_IDLE;
          q_nxt     = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        q_nxt     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_decoder_2to4.sv
// Directed bench for seq_decoder_2to4: a vector table for decode, hold,
// drop and scan behaviour, plus hand sequences for async reset and the
// single-cycle strobe configuration.
module tb_seq_decoder_2to4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v;
  logic [1:0] y;
  logic       scan_en;
  logic [3:0] q4, q1;
  logic       busy4, busy1, done4, done1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_decoder_2to4 #(.N_SEL(2), .HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .v(v), .y(y), .scan_en(scan_en),
    .Q(q4), .busy(busy4), .done(done4)
  );

  seq_decoder_2to4 #(.N_SEL(2), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .v(v), .y(y), .scan_en(scan_en),
    .Q(q1), .busy(busy1), .done(done1)
  );

  typedef struct {
    logic       v;
    logic [1:0] y;
    logic       scan_en;
    logic [3:0] q;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void add(input logic vv, input logic [1:0] yy, input logic ss,
                              input logic [3:0] qq, input logic bb, input logic dd);
    vec_t e;
    e.v = vv; e.y = yy; e.scan_en = ss; e.q = qq; e.busy = bb; e.done = dd;
    tbl.push_back(e);
  endfunction

  // Drive before the edge, then sample 1 time unit after it.
  task automatic step(input logic vv, input logic [1:0] yy, input logic ss);
    @(negedge clk);
    v = vv; y = yy; scan_en = ss;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each row: inputs seen at an edge, outputs expected right after it.
    // Basic decode y=3, hold 4
    add(1, 3, 0, 4'b1000, 1, 0);
    add(0, 0, 0, 4'b1000, 1, 0);
    add(0, 0, 0, 4'b1000, 1, 0);
    add(0, 0, 0, 4'b1000, 1, 0);
    add(0, 0, 0, 4'b0000, 0, 1);
    add(0, 0, 0, 4'b0000, 0, 0);
    // All codes, each new request on the done cycle
    add(1, 0, 0, 4'b0001, 1, 0);
    add(0, 0, 0, 4'b0001, 1, 0);
    add(0, 0, 0, 4'b0001, 1, 0);
    add(0, 0, 0, 4'b0001, 1, 0);
    add(0, 0, 0, 4'b0000, 0, 1);
    add(1, 1, 0, 4'b0010, 1, 0);
    add(0, 0, 0, 4'b0010, 1, 0);
    add(0, 0, 0, 4'b0010, 1, 0);
    add(0, 0, 0, 4'b0010, 1, 0);
    add(0, 0, 0, 4'b0000, 0, 1);
    add(1, 2, 0, 4'b0100, 1, 0);
    add(0, 0, 0, 4'b0100, 1, 0);
    add(0, 0, 0, 4'b0100, 1, 0);
    add(0, 0, 0, 4'b0100, 1, 0);
    add(0, 0, 0, 4'b0000, 0, 1);
    add(1, 3, 0, 4'b1000, 1, 0);
    add(0, 0, 0, 4'b1000, 1, 0);
    add(0, 0, 0, 4'b1000, 1, 0);
    add(0, 0, 0, 4'b1000, 1, 0);
    add(0, 0, 0, 4'b0000, 0, 1);
    add(0, 0, 0, 4'b0000, 0, 0);
    // Dropped request: y=2 arrives while y=1 is held
    add(1, 1, 0, 4'b0010, 1, 0);
    add(0, 0, 0, 4'b0010, 1, 0);
    add(1, 2, 0, 4'b0010, 1, 0);
    add(1, 2, 0, 4'b0010, 1, 0);
    add(0, 0, 0, 4'b0000, 0, 1);
    add(0, 0, 0, 4'b0000, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 0);
    // Scan for 6 cycles (v ignored mid-scan), then release
    add(0, 0, 1, 4'b0001, 1, 0);
    add(0, 0, 1, 4'b0010, 1, 0);
    add(0, 0, 1, 4'b0100, 1, 0);
    add(0, 0, 1, 4'b1000, 1, 0);
    add(1, 3, 1, 4'b0001, 1, 0);
    add(0, 0, 1, 4'b0010, 1, 0);
    add(0, 0, 0, 4'b0000, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 0);
    // v wins over scan_en in idle; scan_en ignored during hold
    add(1, 2, 1, 4'b0100, 1, 0);
    add(0, 0, 1, 4'b0100, 1, 0);
    add(0, 0, 1, 4'b0100, 1, 0);
    add(0, 0, 1, 4'b0100, 1, 0);
    add(0, 0, 1, 4'b0000, 0, 1);
    add(0, 0, 0, 4'b0000, 0, 0);

    v = 0; y = 0; scan_en = 0;
    rst_n = 0;
    #2;
    chk("reset_q",    {28'd0, q4},    32'd0);
    chk("reset_busy", {31'd0, busy4}, 32'd0);
    chk("reset_done", {31'd0, done4}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].y, tbl[i].scan_en);
      chk($sformatf("vec%0d_q", i),    {28'd0, q4},    {28'd0, tbl[i].q});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy4}, {31'd0, tbl[i].busy});
      chk($sformatf("vec%0d_done", i), {31'd0, done4}, {31'd0, tbl[i].done});
      chk($sformatf("vec%0d_onehot0", i), {31'd0, $onehot0(q4)}, 32'd1);
    end

    // Asynchronous reset in the second cycle of a hold
    step(1, 2, 0);
    chk("rsthold_start_q", {28'd0, q4}, 32'h4);
    step(0, 0, 0);
    chk("rsthold_cyc2_q", {28'd0, q4}, 32'h4);
    #2;
    rst_n = 0;
    #1;
    chk("rsthold_async_q",    {28'd0, q4},    32'd0);
    chk("rsthold_async_busy", {31'd0, busy4}, 32'd0);
    chk("rsthold_async_done", {31'd0, done4}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0);
      chk($sformatf("rsthold_after%0d", i), {26'd0, q4, busy4, done4}, 32'd0);
    end

    // Single-cycle strobe on the HOLD_CYCLES=1 instance
    step(1, 0, 0);
    chk("h1_q",    {28'd0, q1},    32'h1);
    chk("h1_busy", {31'd0, busy1}, 32'd1);
    chk("h1_done", {31'd0, done1}, 32'd0);
    step(0, 0, 0);
    chk("h1_rel_q",    {28'd0, q1},    32'd0);
    chk("h1_rel_busy", {31'd0, busy1}, 32'd0);
    chk("h1_rel_done", {31'd0, done1}, 32'd1);
    step(0, 0, 0);
    chk("h1_idle_done", {31'd0, done1}, 32'd0);
    chk("h1_idle_q",    {28'd0, q1},    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_decoder_2to4.md
Name: seq_decoder_2to4

Overview:
- Registered 2-to-4 decoder. It is the inverse of the team's 4-to-2 priority encoder: it takes an encoded index plus valid {v,y} and drives a one-hot line Q.
- Each decoded line is held for a programmable number of cycles and then released, with a done pulse.
- An optional scan mode walks a single 1 across all outputs.
- Intended use: driving one-hot enables or strobes (e.g. LED or mux selects) downstream of the encoder.

Parameters:
- N_SEL, 2, width of the encoded input. Output width is 2**N_SEL. Default gives 4 outputs.
- HOLD_CYCLES, 4, number of cycles a decoded line stays high. Legal range is 1 to 255.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- v  input  1  request valid, sampled each rising edge.
- y  input  N_SEL  encoded index of the line to assert.
- scan_en  input  1  level; requests scan mode.
- Q  output  2**N_SEL  one-hot (or all-zero) decoded output, registered.
- busy  output  1  high while a hold or scan is in progress, registered.
- done  output  1  one-cycle pulse when a hold completes, registered.

Behaviour:
- Interface (decided): one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset, asserted at any time including mid-hold or mid-scan:
  - state=IDLE, Q=0, busy=0, done=0, hold counter=0.
  - Takes effect immediately, without waiting for a clock edge.
- States: IDLE, HOLD, SCAN. The busy register tracks exactly (state != IDLE).
- All outputs are registered. No combinational path from any input to any output.
- IDLE:
  - v=1 at edge k: capture y. At edge k, Q <= 1<<y, busy <= 1, counter <= HOLD_CYCLES-1, go to HOLD.
  - v=0 and scan_en=1: Q <= 1 (bit 0), busy <= 1, go to SCAN.
  - v has priority over scan_en when both are high.
  - Otherwise Q stays 0.
- HOLD:
  - Q is held constant. Counter decrements once per cycle.
  - v, y and scan_en are ignored; requests arriving during HOLD are dropped, not queued.
  - When counter==0 at an edge: Q <= 0, busy <= 0, done <= 1, go to IDLE.
  - Result: Q is high for exactly HOLD_CYCLES cycles. HOLD_CYCLES=1 gives a single-cycle strobe.
- done:
  - High for exactly one cycle, the first IDLE cycle after a hold.
  - A v sampled during that done cycle is accepted, giving back-to-back holds with one idle gap cycle.
- SCAN:
  - Each edge with scan_en=1: Q rotates left by one. The MSB wraps to bit 0 (1000 -> 0001).
  - Edge with scan_en=0: Q <= 0, busy <= 0, go to IDLE. No done pulse.
  - v is ignored in SCAN.
- Width rules:
  - Counter is 8 bits and counts down only; it never underflows, because exit happens at 0.
  - y is interpreted as unsigned; every value from 0 to 2**N_SEL-1 is legal.
- Invariant: Q is always zero or exactly one-hot, never multi-hot, in every state.

Decomposition:
- Shared include file seq_dec_defs.vh holds:
  - state encodings: ST_IDLE=2'd0, ST_HOLD=2'd1, ST_SCAN=2'd2;
  - the default HOLD_CYCLES constant.
- State 2'd3 is illegal and must recover to IDLE with Q=0.
- One natural sub-module, hold_timer:
  - loadable 8-bit down-counter with load and dec inputs and a zero flag;
  - asynchronous active-low reset.

Test Plan:
- Reset mid-hold: v=1, y=2, then rst_n=0 at cycle 2 of the hold -> Q=0000, busy=0, done=0 immediately; no done pulse after release.
- Basic decode, HOLD_CYCLES=4: v=1, y=3 for one cycle -> Q=1000 for exactly 4 cycles, busy high for the same 4 cycles, then Q=0000 and done=1 for 1 cycle.
- All codes: y=0,1,2,3, each sent on its done cycle -> Q=0001, 0010, 0100, 1000 in sequence; one gap cycle between holds; never multi-hot.
- Dropped request: v=1, y=1, then v=1, y=2 two cycles later while busy -> only 0010 appears; no 0100 is ever output; exactly one done pulse.
- Scan: scan_en=1 for 6 cycles with v=0 -> Q=0001, 0010, 0100, 1000, 0001, 0010; after deassert Q=0000, busy=0, done stays 0. With v=1 and scan_en=1 simultaneously in IDLE, HOLD is entered.
- HOLD_CYCLES=1: v=1, y=0 -> Q=0001 for exactly 1 cycle, then done=1 for 1 cycle.
